// File: rtl/avmm_pkg.sv
// Shared types for the Avalon-MM memory responder: word geometry, FSM states, read-return beat.
package avmm_pkg;

    localparam int unsigned WORD_W         = 32;
    localparam int unsigned BYTES_PER_WORD = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        STALL = 1'b1
    } resp_state_t;

    typedef struct packed {
        logic              valid;
        logic [WORD_W-1:0] data;
    } rd_beat_t;

endpackage

// File: rtl/avmm_rd_pipe.sv
// Fixed-latency read return pipeline; data is zero in every stage that holds no valid beat.
module avmm_rd_pipe
    import avmm_pkg::*;
#(
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [WORD_W-1:0] data_i,
    output logic              valid_o,
    output logic [WORD_W-1:0] data_o,
    output logic              ret_o
);

    rd_beat_t stage_q [LATENCY];
    rd_beat_t in_c;

    assign in_c.valid = push_i;
    assign in_c.data  = push_i ? data_i : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= in_c;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign valid_o = stage_q[LATENCY-1].valid;
    assign data_o  = stage_q[LATENCY-1].data;
    // A beat leaving the last stage frees one pending slot.
    assign ret_o   = stage_q[LATENCY-1].valid;

endmodule

// File: rtl/avmm_mem_responder.sv
// Avalon-MM slave word memory with programmable command stall and pipelined in-order reads.
// Optional byte-lane writes are enabled with AVMM_BYTEENABLE_EN.
module avmm_mem_responder
    import avmm_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS  = 1024,
    parameter int unsigned WAIT_CYCLES  = 1,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned MAX_PENDING  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           slave_address,
    input  logic                  slave_read,
    input  logic                  slave_write,
    input  logic [31:0]           slave_writedata,
`ifdef AVMM_BYTEENABLE_EN
    input  logic [3:0]            slave_byteenable,
`endif
    output logic                  slave_waitrequest,
    output logic [31:0]           slave_readdata,
    output logic                  slave_readdatavalid
);

    localparam int unsigned AW     = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned PEND_W = $clog2(MAX_PENDING + 1);

    resp_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

    logic [AW-1:0]             idx_c;
    logic [BYTES_PER_WORD-1:0] be_c;
    logic                      cmd_c, wr_c, rd_c, read_ok_c, accept_c, ret_c;
    logic                      wr_acc_c, rd_acc_c;
    logic                      unused_addr_c;

    assign idx_c         = slave_address[AW+1:2];
    assign unused_addr_c = ^{slave_address[31:AW+2], slave_address[1:0]};

`ifdef AVMM_BYTEENABLE_EN
    assign be_c = slave_byteenable;
`else
    assign be_c = '1;
`endif

    // Write wins when both strobes are high; the read is simply dropped.
    assign cmd_c     = slave_read | slave_write;
    assign wr_c      = slave_write;
    assign rd_c      = slave_read & ~slave_write;
    assign read_ok_c = ~rd_c | (pend_q < PEND_W'(MAX_PENDING)) | ret_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    // Stall sequencing: the counter saturates at WAIT_CYCLES while a read waits for a slot.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept_c = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (cmd_c) begin
                    if (WAIT_CYCLES == 0) begin
                        if (read_ok_c) begin
                            accept_c = 1'b1;
                        end else begin
                            state_d = STALL;
                        end
                    end else begin
                        state_d = STALL;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            STALL: begin
                if (!cmd_c) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if ((cnt_q == CNT_W'(WAIT_CYCLES)) && read_ok_c) begin
                    accept_c = 1'b1;
                    state_d  = IDLE;
                    cnt_d    = '0;
                end else if (cnt_q < CNT_W'(WAIT_CYCLES)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign slave_waitrequest = ~accept_c;
    assign wr_acc_c          = accept_c & wr_c;
    assign rd_acc_c          = accept_c & rd_c;

    always_comb begin
        pend_d = pend_q;
        if (rd_acc_c && !ret_c) begin
            pend_d = pend_q + PEND_W'(1);
        end else if (!rd_acc_c && ret_c) begin
            pend_d = pend_q - PEND_W'(1);
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_acc_c) begin
            for (int unsigned b = 0; b < BYTES_PER_WORD; b++) begin
                if (be_c[b]) begin
                    mem_q[idx_c][8*b +: 8] <= slave_writedata[8*b +: 8];
                end
            end
        end
    end

    avmm_rd_pipe #(
        .LATENCY (READ_LATENCY)
    ) u_rd_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (rd_acc_c),
        .data_i  (mem_q[idx_c]),
        .valid_o (slave_readdatavalid),
        .data_o  (slave_readdata),
        .ret_o   (ret_c)
    );

endmodule
